// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue-side controller: ALU ctrl codes,
// ALUOp / funct encodings, controller states and multiply iteration count.
package alu_pkg;

  localparam int DATA_W    = 32;
  localparam int CTRL_W    = 4;
  localparam int MUL_ITERS = 32;

  // ALU ctrl codes. CTRL_MUL is an internal tag only; the ALU never sees it,
  // multiply is carried out as repeated CTRL_ADD passes.
  localparam logic [CTRL_W-1:0] CTRL_AND  = 4'b0000;
  localparam logic [CTRL_W-1:0] CTRL_OR   = 4'b0001;
  localparam logic [CTRL_W-1:0] CTRL_ADD  = 4'b0010;
  localparam logic [CTRL_W-1:0] CTRL_SUB  = 4'b0110;
  localparam logic [CTRL_W-1:0] CTRL_SLT  = 4'b0111;
  localparam logic [CTRL_W-1:0] CTRL_SLTU = 4'b0101;
  localparam logic [CTRL_W-1:0] CTRL_MUL  = 4'b1000;

  // ALUOp encodings
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_SLT   = 3'b011;
  localparam logic [2:0] ALUOP_SLTU  = 3'b100;
  localparam logic [2:0] ALUOP_OR    = 3'b101;
  localparam logic [2:0] ALUOP_AND   = 3'b110;

  // R-type funct encodings
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU = 6'b101011;
  localparam logic [5:0] FUNCT_MUL  = 6'b011000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of (ALUOp, funct) into ALU ctrl, multiply and illegal flags.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0]        aluop_i,
  input  logic [5:0]        funct_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              is_mul_o,
  output logic              illegal_o
);

  // Map request encodings onto ALU ctrl; anything unlisted is illegal
  always_comb begin
    ctrl_o    = CTRL_AND;
    is_mul_o  = 1'b0;
    illegal_o = 1'b0;
    case (aluop_i)
      ALUOP_ADD:  ctrl_o = CTRL_ADD;
      ALUOP_SUB:  ctrl_o = CTRL_SUB;
      ALUOP_SLT:  ctrl_o = CTRL_SLT;
      ALUOP_SLTU: ctrl_o = CTRL_SLTU;
      ALUOP_OR:   ctrl_o = CTRL_OR;
      ALUOP_AND:  ctrl_o = CTRL_AND;
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD:  ctrl_o = CTRL_ADD;
          FUNCT_SUB:  ctrl_o = CTRL_SUB;
          FUNCT_AND:  ctrl_o = CTRL_AND;
          FUNCT_OR:   ctrl_o = CTRL_OR;
          FUNCT_SLT:  ctrl_o = CTRL_SLT;
          FUNCT_SLTU: ctrl_o = CTRL_SLTU;
          FUNCT_MUL: begin
            ctrl_o   = CTRL_MUL;
            is_mul_o = 1'b1;
          end
          default:    illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue-side ALU controller: single-pass ops in one EXEC cycle, MUL as a
// 32-iteration shift-add that borrows the external ALU as its adder.
module alu_op_sequencer
  import alu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        aluop_i,
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  input  logic [DATA_W-1:0] alu_result_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              done_o,
  output logic              illegal_o
);

  localparam logic [5:0] MUL_LAST = 6'(MUL_ITERS - 1);

  state_t            state;
  logic [DATA_W-1:0] op_a;      // operand 1; multiplicand (shifted left) in MUL
  logic [DATA_W-1:0] op_b;      // operand 2; multiplier (shifted right) in MUL
  logic [DATA_W-1:0] acc;
  logic [5:0]        count;
  logic [CTRL_W-1:0] ctrl_q;
  logic              illegal_q;

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_is_mul;
  logic              dec_illegal;

  alu_op_decode u_decode (
    .aluop_i   (aluop_i),
    .funct_i   (funct_i),
    .ctrl_o    (dec_ctrl),
    .is_mul_o  (dec_is_mul),
    .illegal_o (dec_illegal)
  );

  assign ready_o = (state == ST_IDLE);

  // ALU drive: quiet in IDLE and for illegal ops, latched op in EXEC, add step in MUL
  always_comb begin
    alu_ctrl_o = CTRL_AND;
    alu_src1_o = '0;
    alu_src2_o = '0;
    case (state)
      ST_EXEC: begin
        if (!illegal_q) begin
          alu_ctrl_o = ctrl_q;
          alu_src1_o = op_a;
          alu_src2_o = op_b;
        end
      end
      ST_MUL: begin
        alu_ctrl_o = CTRL_ADD;
        alu_src1_o = acc;
        alu_src2_o = op_b[0] ? op_a : '0;
      end
      default: ;
    endcase
  end

  // Controller FSM with registered result, zero, done and illegal outputs
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= ST_IDLE;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      count     <= '0;
      ctrl_q    <= CTRL_AND;
      illegal_q <= 1'b0;
      result_o  <= '0;
      zero_o    <= 1'b1;
      done_o    <= 1'b0;
      illegal_o <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      illegal_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            op_a      <= src1_i;
            op_b      <= src2_i;
            ctrl_q    <= dec_ctrl;
            illegal_q <= dec_illegal;
            acc       <= '0;
            count     <= '0;
            state     <= dec_is_mul ? ST_MUL : ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_o  <= illegal_q ? '0 : alu_result_i;
          zero_o    <= illegal_q ? 1'b1 : (alu_result_i == '0);
          done_o    <= 1'b1;
          illegal_o <= illegal_q;
          state     <= ST_IDLE;
        end
        ST_MUL: begin
          acc   <= alu_result_i;
          op_a  <= op_a << 1;
          op_b  <= op_b >> 1;
          count <= count + 6'd1;
          if (count == MUL_LAST) begin
            result_o <= alu_result_i;
            zero_o   <= (alu_result_i == '0);
            done_o   <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU beside the DUT.
module tb_alu_op_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  aluop_i;
  logic [5:0]  funct_i;
  logic [31:0] src1_i, src2_i;
  logic [3:0]  alu_ctrl_o;
  logic [31:0] alu_src1_o, alu_src2_o;
  logic [31:0] alu_result_i;
  logic [31:0] result_o;
  logic        zero_o, done_o, illegal_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  alu_op_sequencer dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .aluop_i      (aluop_i),
    .funct_i      (funct_i),
    .src1_i       (src1_i),
    .src2_i       (src2_i),
    .alu_ctrl_o   (alu_ctrl_o),
    .alu_src1_o   (alu_src1_o),
    .alu_src2_o   (alu_src2_o),
    .alu_result_i (alu_result_i),
    .result_o     (result_o),
    .zero_o       (zero_o),
    .done_o       (done_o),
    .illegal_o    (illegal_o)
  );

  // Behavioural ALU
  always_comb begin
    alu_result_i = 32'h0;
    case (alu_ctrl_o)
      4'b0000: alu_result_i = alu_src1_o & alu_src2_o;
      4'b0001: alu_result_i = alu_src1_o | alu_src2_o;
      4'b0010: alu_result_i = alu_src1_o + alu_src2_o;
      4'b0110: alu_result_i = alu_src1_o - alu_src2_o;
      4'b0111: alu_result_i = {31'h0, $signed(alu_src1_o) < $signed(alu_src2_o)};
      4'b0101: alu_result_i = {31'h0, alu_src1_o < alu_src2_o};
      default: alu_result_i = 32'h0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request while idle; returns #1 after the accepting edge
  task automatic issue(input logic [2:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    aluop_i = op;
    funct_i = fn;
    src1_i  = a;
    src2_i  = b;
    valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  // Single-pass op: check EXEC cycle, done cycle and the cycle after
  task automatic exec_op(input string tag, input logic [2:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] exp_ctrl, input logic [31:0] exp_res,
                         input logic exp_zero, input logic exp_ill);
    issue(op, fn, a, b);
    check({tag, " exec ready"}, {31'h0, ready_o}, 32'h0);
    check({tag, " exec ctrl"}, {28'h0, alu_ctrl_o}, {28'h0, exp_ctrl});
    check({tag, " exec done"}, {31'h0, done_o}, 32'h0);
    @(posedge clk_i); #1;
    check({tag, " done"}, {31'h0, done_o}, 32'h1);
    check({tag, " illegal"}, {31'h0, illegal_o}, {31'h0, exp_ill});
    check({tag, " result"}, result_o, exp_res);
    check({tag, " zero"}, {31'h0, zero_o}, {31'h0, exp_zero});
    check({tag, " ready back"}, {31'h0, ready_o}, 32'h1);
    @(posedge clk_i); #1;
    check({tag, " done pulse"}, {31'h0, done_o}, 32'h0);
    check({tag, " illegal pulse"}, {31'h0, illegal_o}, 32'h0);
    check({tag, " result hold"}, result_o, exp_res);
  endtask

  // Multiply: expects exactly 32 add cycles, then done
  task automatic mul_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_zero);
    int n_add;
    int n_early;
    n_add   = 0;
    n_early = 0;
    issue(3'b010, 6'b011000, a, b);
    for (int i = 0; i < 32; i++) begin
      if (alu_ctrl_o == 4'b0010 && !ready_o) n_add++;
      if (done_o) n_early++;
      @(posedge clk_i); #1;
    end
    check({tag, " add cycles"}, n_add, 32);
    check({tag, " early done"}, n_early, 0);
    check({tag, " done"}, {31'h0, done_o}, 32'h1);
    check({tag, " result"}, result_o, exp_res);
    check({tag, " zero"}, {31'h0, zero_o}, {31'h0, exp_zero});
    check({tag, " ready back"}, {31'h0, ready_o}, 32'h1);
    @(posedge clk_i); #1;
    check({tag, " done pulse"}, {31'h0, done_o}, 32'h0);
  endtask

  initial begin
    int n_done;
    rst_i   = 1'b0;
    valid_i = 1'b0;
    aluop_i = 3'b000;
    funct_i = 6'b000000;
    src1_i  = 32'h0;
    src2_i  = 32'h0;

    // Reset
    repeat (2) @(posedge clk_i);
    #1;
    check("rst ready", {31'h0, ready_o}, 32'h1);
    check("rst result", result_o, 32'h0);
    check("rst zero", {31'h0, zero_o}, 32'h1);
    check("rst done", {31'h0, done_o}, 32'h0);
    check("rst illegal", {31'h0, illegal_o}, 32'h0);
    check("rst ctrl", {28'h0, alu_ctrl_o}, 32'h0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Single-pass ops
    exec_op("add",   3'b000, 6'b000000, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, 1'b0);
    exec_op("rsub",  3'b010, 6'b100010, 32'd3, 32'd3, 4'b0110, 32'd0,  1'b1, 1'b0);
    exec_op("slt",   3'b011, 6'b000000, 32'hFFFFFFFF, 32'd1, 4'b0111, 32'd1, 1'b0, 1'b0);
    exec_op("sltu",  3'b100, 6'b000000, 32'hFFFFFFFF, 32'd1, 4'b0101, 32'd0, 1'b1, 1'b0);
    exec_op("or",    3'b101, 6'b000000, 32'h000000F0, 32'h0000000F, 4'b0001, 32'h000000FF, 1'b0, 1'b0);
    exec_op("and",   3'b110, 6'b000000, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0000, 32'h00F000F0, 1'b0, 1'b0);
    exec_op("sub",   3'b001, 6'b000000, 32'd1, 32'd2, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b0);
    exec_op("rsltu", 3'b010, 6'b101011, 32'd1, 32'hFFFFFFFF, 4'b0101, 32'd1, 1'b0, 1'b0);

    // Illegal ops clear a nonzero result
    exec_op("ill funct", 3'b010, 6'b000000, 32'd9, 32'd9, 4'b0000, 32'd0, 1'b1, 1'b1);
    exec_op("add2",      3'b000, 6'b000000, 32'd1, 32'd1, 4'b0010, 32'd2, 1'b0, 1'b0);
    exec_op("ill op",    3'b111, 6'b100000, 32'd4, 32'd4, 4'b0000, 32'd0, 1'b1, 1'b1);

    // Multiply
    mul_op("mul neg1x3", 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 1'b0);
    mul_op("mul wrap",   32'h00010000, 32'h00010000, 32'h0, 1'b1);
    mul_op("mul 5x7",    32'd5, 32'd7, 32'd35, 1'b0);

    // Reset in the middle of a multiply aborts it without done
    issue(3'b010, 6'b011000, 32'd6, 32'd9);
    repeat (9) @(posedge clk_i);
    #1;
    check("abort busy", {31'h0, ready_o}, 32'h0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    check("abort ready", {31'h0, ready_o}, 32'h1);
    check("abort done", {31'h0, done_o}, 32'h0);
    check("abort ctrl", {28'h0, alu_ctrl_o}, 32'h0);
    check("abort result", result_o, 32'h0);
    check("abort zero", {31'h0, zero_o}, 32'h1);
    n_done = 0;
    repeat (30) begin
      @(posedge clk_i); #1;
      if (done_o) n_done++;
    end
    check("abort no late done", n_done, 0);

    // Operation after abort
    exec_op("post add", 3'b000, 6'b000000, 32'hFFFFFFFF, 32'd1, 4'b0010, 32'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
